// File: rtl/bus_burst_master_pkg.sv
// Shared definitions for the burst bus master: state encoding and bus widths.
package bus_burst_master_pkg;

  localparam int DATA_W  = 32;
  localparam int BURST_W = 8;
  localparam int BE_W    = 4;

  typedef enum logic [2:0] {
    stIdle     = 3'd0,
    stRequest  = 3'd1,
    stBegin    = 3'd2,
    stWrite    = 3'd3,
    stWriteEnd = 3'd4,
    stRead     = 3'd5,
    stAbort    = 3'd6
  } busState_t;

endpackage

// File: rtl/bus_burst_master.sv
// Single-master burst engine: takes one client command, wins the bus through the
// arbiter, runs begin/data/end and reports done or error back to the client.
module bus_burst_master
  import bus_burst_master_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               cmdValid,
  output logic               cmdReady,
  input  logic [DATA_W-1:0]  cmdAddress,
  input  logic [BURST_W-1:0] cmdBurstSize,
  input  logic               cmdReadNotWrite,
  input  logic [BE_W-1:0]    cmdByteEnables,
  input  logic [DATA_W-1:0]  wrData,
  input  logic               wrValid,
  output logic               wrReady,
  output logic [DATA_W-1:0]  rdData,
  output logic               rdValid,
  output logic               done,
  output logic               error,
  output logic               busRequest,
  input  logic               busGrant,
  output logic               beginTransactionOut,
  output logic               endTransactionOut,
  output logic               dataValidOut,
  output logic [DATA_W-1:0]  addressDataOut,
  output logic [BE_W-1:0]    byteEnablesOut,
  output logic               readNotWriteOut,
  output logic [BURST_W-1:0] burstSizeOut,
  input  logic [DATA_W-1:0]  addressDataIn,
  input  logic               dataValidIn,
  input  logic               endTransactionIn,
  input  logic               busErrorIn,
  output logic [2:0]         stateDebug
);

  // Handshakes: a command (cmdValid & cmdReady) or a write word (wrValid & wrReady)
  // transfers on the rising edge where both are high; ready never depends on valid.
  // rdValid has no backpressure and must be consumed the cycle it is high.

  busState_t          state;
  logic [DATA_W-1:0]  latAddress;
  logic [BURST_W-1:0] latBurst;
  logic               latRnw;
  logic [BE_W-1:0]    latByteEnables;
  logic [BURST_W-1:0] wordCount;
  logic               errorHit;

  assign cmdReady   = (state == stIdle);
  assign wrReady    = (state == stWrite);
  assign stateDebug = state;

  // A bus error only matters while this master owns the bus.
  assign errorHit = busErrorIn &&
                    (state == stBegin || state == stWrite ||
                     state == stWriteEnd || state == stRead);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= stIdle;
      latAddress          <= '0;
      latBurst            <= '0;
      latRnw              <= 1'b0;
      latByteEnables      <= '0;
      wordCount           <= '0;
      busRequest          <= 1'b0;
      beginTransactionOut <= 1'b0;
      endTransactionOut   <= 1'b0;
      dataValidOut        <= 1'b0;
      addressDataOut      <= '0;
      byteEnablesOut      <= '0;
      readNotWriteOut     <= 1'b0;
      burstSizeOut        <= '0;
      rdData              <= '0;
      rdValid             <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
    end else begin
      // Everything on the bus returns to zero unless a state drives it this cycle,
      // which keeps the outputs safe to OR with other masters.
      busRequest          <= 1'b0;
      beginTransactionOut <= 1'b0;
      endTransactionOut   <= 1'b0;
      dataValidOut        <= 1'b0;
      addressDataOut      <= '0;
      byteEnablesOut      <= '0;
      readNotWriteOut     <= 1'b0;
      burstSizeOut        <= '0;
      rdData              <= '0;
      rdValid             <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;

      if (state == stRead && dataValidIn) begin
        rdValid <= 1'b1;
        rdData  <= addressDataIn;
      end

      if (errorHit) begin
        // A slave that also ends the transaction has already closed the bus.
        error             <= 1'b1;
        endTransactionOut <= !endTransactionIn;
        state             <= endTransactionIn ? stIdle : stAbort;
      end else begin
        case (state)
          stIdle: begin
            if (cmdValid) begin
              latAddress     <= cmdAddress;
              latBurst       <= cmdBurstSize;
              latRnw         <= cmdReadNotWrite;
              latByteEnables <= cmdByteEnables;
              wordCount      <= cmdBurstSize;
              busRequest     <= 1'b1;
              state          <= stRequest;
            end
          end
          stRequest: begin
            if (busGrant) begin
              beginTransactionOut <= 1'b1;
              addressDataOut      <= latAddress;
              byteEnablesOut      <= latByteEnables;
              readNotWriteOut     <= latRnw;
              burstSizeOut        <= latBurst;
              state               <= stBegin;
            end else begin
              busRequest <= 1'b1;
            end
          end
          stBegin: begin
            state <= latRnw ? stRead : stWrite;
          end
          stWrite: begin
            if (wrValid) begin
              dataValidOut   <= 1'b1;
              addressDataOut <= wrData;
              if (wordCount == '0) begin
                state <= stWriteEnd;
              end else begin
                wordCount <= wordCount - 8'd1;
              end
            end
          end
          stWriteEnd: begin
            endTransactionOut <= 1'b1;
            done              <= 1'b1;
            state             <= stIdle;
          end
          stRead: begin
            if (endTransactionIn) begin
              done  <= 1'b1;
              state <= stIdle;
            end
          end
          stAbort: begin
            state <= stIdle;
          end
          default: begin
            state <= stIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_burst_master.sv
// Directed bench for bus_burst_master: write, read, stall, error, grant wait and
// mid-transaction reset, with a read-data expected queue.
module tb_bus_burst_master;
  import bus_burst_master_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdAddress;
  logic [7:0]  cmdBurstSize;
  logic        cmdReadNotWrite;
  logic [3:0]  cmdByteEnables;
  logic [31:0] wrData;
  logic        wrValid;
  logic        wrReady;
  logic [31:0] rdData;
  logic        rdValid;
  logic        done;
  logic        error;
  logic        busRequest;
  logic        busGrant;
  logic        beginTransactionOut;
  logic        endTransactionOut;
  logic        dataValidOut;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic        readNotWriteOut;
  logic [7:0]  burstSizeOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic [2:0]  stateDebug;

  int checkCount = 0;
  int failCount  = 0;
  int doneCount  = 0;
  int errorCount = 0;
  int rdCount    = 0;
  logic [31:0] exp_q[$];
  logic [9:0]  readPattern = 10'b1111001111;

  bus_burst_master dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddress(cmdAddress),
    .cmdBurstSize(cmdBurstSize), .cmdReadNotWrite(cmdReadNotWrite),
    .cmdByteEnables(cmdByteEnables),
    .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
    .rdData(rdData), .rdValid(rdValid), .done(done), .error(error),
    .busRequest(busRequest), .busGrant(busGrant),
    .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
    .dataValidOut(dataValidOut), .addressDataOut(addressDataOut),
    .byteEnablesOut(byteEnablesOut), .readNotWriteOut(readNotWriteOut),
    .burstSizeOut(burstSizeOut),
    .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn),
    .stateDebug(stateDebug)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [63:0] observed,
                          input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] busOuts();
    return {15'b0, busRequest, beginTransactionOut, endTransactionOut, dataValidOut,
            readNotWriteOut, byteEnablesOut, burstSizeOut, addressDataOut};
  endfunction

  // Scoreboard: read words and completion pulses
  always @(negedge clock) begin
    if (rdValid) begin
      rdCount++;
      if (exp_q.size() == 0) checkVal("rdUnexpected", 64'(rdValid), 64'd0);
      else checkVal("rdData", 64'(rdData), 64'(exp_q.pop_front()));
    end
    if (done) doneCount++;
    if (error) errorCount++;
  end

  task automatic step();
    @(negedge clock);
  endtask

  // Issues a command from IDLE and returns at the BEGIN cycle.
  task automatic startBurst(input logic [31:0] addr, input logic [7:0] burst,
                            input logic rnw, input logic [3:0] be, input int grantDelay);
    checkVal("cmdReadyIdle", 64'(cmdReady), 64'd1);
    cmdValid = 1'b1; cmdAddress = addr; cmdBurstSize = burst;
    cmdReadNotWrite = rnw; cmdByteEnables = be;
    step();
    cmdValid = 1'b0;
    checkVal("busRequest", 64'(busRequest), 64'd1);
    checkVal("cmdReadyBusy", 64'(cmdReady), 64'd0);
    for (int i = 0; i < grantDelay; i++) begin
      step();
      checkVal("requestHeld", 64'({beginTransactionOut, busRequest}), 64'd1);
    end
    busGrant = 1'b1;
    step();
    busGrant = 1'b0;
    checkVal("beginPhase", busOuts(),
             {15'b0, 1'b0, 1'b1, 1'b0, 1'b0, rnw, be, burst, addr});
  endtask

  initial begin
    int doneBefore;
    int errBefore;
    int rdBefore;
    int w;

    reset = 1'b0; cmdValid = 1'b0; cmdAddress = '0; cmdBurstSize = '0;
    cmdReadNotWrite = 1'b0; cmdByteEnables = '0; wrData = '0; wrValid = 1'b0;
    busGrant = 1'b0; addressDataIn = '0; dataValidIn = 1'b0;
    endTransactionIn = 1'b0; busErrorIn = 1'b0;

    #1;
    checkVal("resetBus", busOuts(), 64'd0);
    checkVal("resetState", 64'(stateDebug), 64'(stIdle));
    checkVal("resetClient", 64'({rdValid, done, error, wrReady, rdData}), 64'd0);
    step(); step();
    reset = 1'b1;
    step();

    // Write burst of 4, grant one cycle after the first request cycle
    doneBefore = doneCount;
    startBurst(32'h0000_1000, 8'd3, 1'b0, 4'hF, 1);
    wrValid = 1'b1; wrData = 32'hA0;
    step();
    checkVal("wrReadyWrite", 64'(wrReady), 64'd1);
    checkVal("noDataYet", 64'(dataValidOut), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wrData = 32'(32'hA0 + i);
      step();
      checkVal("writeData", 64'({dataValidOut, addressDataOut}), 64'({1'b1, 32'(32'hA0 + i)}));
    end
    wrValid = 1'b0; wrData = '0;
    checkVal("noEarlyEnd", 64'(endTransactionOut), 64'd0);
    step();
    checkVal("writeEnd", 64'({endTransactionOut, done, dataValidOut}), 64'b110);
    step();
    checkVal("busIdleAfterWrite", busOuts(), 64'd0);
    checkVal("writeDoneOnce", 64'(doneCount - doneBefore), 64'd1);

    // Read burst of 8 with a two-cycle gap, end with the last word
    doneBefore = doneCount; rdBefore = rdCount; w = 0;
    startBurst(32'h0000_0040, 8'd7, 1'b1, 4'hF, 0);
    step();
    for (int c = 0; c < 10; c++) begin
      dataValidIn = readPattern[c];
      addressDataIn = readPattern[c] ? 32'(32'h10 + w) : 32'h0;
      endTransactionIn = (c == 9);
      if (readPattern[c]) begin
        exp_q.push_back(32'(32'h10 + w));
        w++;
      end
      step();
      checkVal("noEndOutRead", 64'(endTransactionOut), 64'd0);
    end
    dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b0;
    checkVal("readDone", 64'({done, stateDebug}), 64'({1'b1, stIdle}));
    step();
    checkVal("readQueueEmpty", 64'(exp_q.size()), 64'd0);
    checkVal("readWordCount", 64'(rdCount - rdBefore), 64'd8);
    checkVal("readDoneOnce", 64'(doneCount - doneBefore), 64'd1);
    checkVal("busIdleAfterRead", busOuts(), 64'd0);

    // Write stall: wrValid withheld five cycles
    startBurst(32'h0000_2000, 8'd1, 1'b0, 4'h3, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      checkVal("stallReady", 64'(wrReady), 64'd1);
      step();
      checkVal("stallNoData", 64'(dataValidOut), 64'd0);
    end
    wrValid = 1'b1; wrData = 32'hB0;
    step();
    checkVal("stallWord0", 64'({dataValidOut, addressDataOut}), 64'({1'b1, 32'hB0}));
    wrData = 32'hB1;
    step();
    wrValid = 1'b0; wrData = '0;
    checkVal("stallWord1", 64'({endTransactionOut, dataValidOut, addressDataOut}),
             64'({1'b0, 1'b1, 32'hB1}));
    step();
    checkVal("stallEnd", 64'({endTransactionOut, done}), 64'b11);
    step();

    // Bus error after one read word
    doneBefore = doneCount; errBefore = errorCount;
    startBurst(32'h0000_0300, 8'd3, 1'b1, 4'hF, 0);
    step();
    dataValidIn = 1'b1; addressDataIn = 32'h55; exp_q.push_back(32'h55);
    step();
    dataValidIn = 1'b0; addressDataIn = '0; busErrorIn = 1'b1;
    step();
    busErrorIn = 1'b0;
    checkVal("abortState", 64'(stateDebug), 64'(stAbort));
    checkVal("abortOutputs", 64'({endTransactionOut, error, done}), 64'b110);
    step();
    checkVal("abortBusIdle", busOuts(), 64'd0);
    checkVal("abortToIdle", 64'(stateDebug), 64'(stIdle));
    checkVal("abortErrorOnce", 64'(errorCount - errBefore), 64'd1);
    checkVal("abortNoDone", 64'(doneCount - doneBefore), 64'd0);

    // Bus error coincident with slave end
    errBefore = errorCount;
    startBurst(32'h0000_0400, 8'd3, 1'b1, 4'hF, 0);
    step();
    busErrorIn = 1'b1; endTransactionIn = 1'b1;
    step();
    busErrorIn = 1'b0; endTransactionIn = 1'b0;
    checkVal("errEndOutputs", 64'({endTransactionOut, error, done}), 64'b010);
    checkVal("errEndIdle", 64'({cmdReady, stateDebug}), 64'({1'b1, stIdle}));
    step();
    checkVal("errEndErrorOnce", 64'(errorCount - errBefore), 64'd1);
    checkVal("errEndNoDone", 64'(doneCount - doneBefore), 64'd0);

    // Grant withheld 50 cycles while a second command is held
    cmdValid = 1'b1; cmdAddress = 32'h0000_5000; cmdBurstSize = 8'd0;
    cmdReadNotWrite = 1'b1; cmdByteEnables = 4'hF;
    step();
    cmdAddress = 32'h0000_6000; cmdReadNotWrite = 1'b0; cmdBurstSize = 8'd9;
    for (int i = 0; i < 50; i++) begin
      checkVal("waitRequest", 64'({busRequest, beginTransactionOut, cmdReady}), 64'b100);
      if (i == 49) begin
        cmdValid = 1'b0;
        busGrant = 1'b1;
      end
      step();
    end
    busGrant = 1'b0;
    checkVal("waitBegin", busOuts(),
             {15'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 8'd0, 32'h0000_5000});
    step();
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    checkVal("waitDone", 64'({done, stateDebug}), 64'({1'b1, stIdle}));
    step();

    // Asynchronous reset after two of four write words
    startBurst(32'h0000_7000, 8'd3, 1'b0, 4'hF, 0);
    wrValid = 1'b1; wrData = 32'hC0;
    step();
    step();
    wrData = 32'hC1;
    step();
    checkVal("preResetWord", 64'({dataValidOut, addressDataOut}), 64'({1'b1, 32'hC1}));
    doneBefore = doneCount; errBefore = errorCount;
    #2;
    reset = 1'b0;
    wrValid = 1'b0; wrData = '0;
    #1;
    checkVal("asyncResetBus", busOuts(), 64'd0);
    checkVal("asyncResetState", 64'(stateDebug), 64'(stIdle));
    checkVal("asyncResetClient", 64'({rdValid, done, error, wrReady}), 64'd0);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("postResetQuiet", busOuts(), 64'd0);
    end
    checkVal("postResetReady", 64'(cmdReady), 64'd1);
    checkVal("postResetNoDone", 64'(doneCount - doneBefore), 64'd0);
    checkVal("postResetNoError", 64'(errorCount - errBefore), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
